lsu: RTL

Per-thread load/store unit. Each thread has one instance. It turns a decoded LDR/STR into a single read or write transaction on one consumer port of the data-memory `controller`. It captures load data into `lsu_out`, and reports progress to the core scheduler through `lsu_state`. It sits directly upstream of the data-memory `controller`: one `lsu` drives one consumer index.

---
 rtl/gpu_pkg.sv | 27 ++
 rtl/lsu.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/gpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gpu_pkg : scheduler and LSU state encodings shared across the core         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package gpu_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    REQUEST = 3'd3,
    WAIT    = 3'd4,
    EXECUTE = 3'd5,
    UPDATE  = 3'd6,
    DONE    = 3'd7
  } core_state_t;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'd0,
    LSU_REQUESTING = 2'd1,
    LSU_WAITING    = 2'd2,
    LSU_DONE       = 2'd3
  } lsu_state_t;

endpackage
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsu : per-thread load/store unit issuing one read or write per LDR/STR     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lsu
  import gpu_pkg::*;
#(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  core_state_t          core_state,
  input  logic                 decoded_mem_read_enable,
  input  logic                 decoded_mem_write_enable,
  input  logic [DATA_BITS-1:0] rs,
  input  logic [DATA_BITS-1:0] rt,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  input  logic                 mem_write_ready,
  output lsu_state_t           lsu_state,
  output logic [DATA_BITS-1:0] lsu_out,
  output logic                 lsu_error
);

  localparam bit C_TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam int C_CNT_W      = C_TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [C_CNT_W-1:0] C_CNT_SAT =
      C_TIMEOUT_EN ? C_CNT_W'(TIMEOUT_CYCLES) : {C_CNT_W{1'b1}};
  localparam logic [C_CNT_W-1:0] C_CNT_LAST =
      C_TIMEOUT_EN ? C_CNT_W'(TIMEOUT_CYCLES - 1) : {C_CNT_W{1'b1}};

  lsu_state_t           state_q,   state_d;
  logic [ADDR_BITS-1:0] addr_q,    addr_d;
  logic [DATA_BITS-1:0] data_q,    data_d;
  logic                 is_read_q, is_read_d;
  logic [C_CNT_W-1:0]   cnt_q,     cnt_d;
  logic [DATA_BITS-1:0] out_q,     out_d;
  logic                 err_q,     err_d;

  logic                 w_grant;
  logic                 w_rs_unused;

  // Only the low address bits of rs are meaningful when DATA_BITS > ADDR_BITS.
  assign w_rs_unused = ^rs;
  assign w_grant     = is_read_q ? mem_read_ready : mem_write_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= LSU_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      is_read_q <= 1'b0;
      cnt_q     <= '0;
      out_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      is_read_q <= is_read_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    data_d          = data_q;
    is_read_d       = is_read_q;
    cnt_d           = cnt_q;
    out_d           = out_q;
    err_d           = err_q;
    mem_read_valid  = 1'b0;
    mem_write_valid = 1'b0;

    case (state_q)
      LSU_IDLE: begin
        if (enable && (core_state == REQUEST) &&
            (decoded_mem_read_enable || decoded_mem_write_enable)) begin
          state_d = LSU_REQUESTING;
        end
      end

      LSU_REQUESTING: begin
        addr_d    = ADDR_BITS'(rs);
        data_d    = rt;
        is_read_d = decoded_mem_read_enable;
        cnt_d     = '0;
        err_d     = 1'b0;
        state_d   = LSU_WAITING;
      end

      LSU_WAITING: begin
        // Valid drops combinationally in the grant cycle so no second grant can follow.
        mem_read_valid  = is_read_q  && !mem_read_ready;
        mem_write_valid = !is_read_q && !mem_write_ready;
        if (w_grant) begin
          if (is_read_q) begin
            out_d = mem_read_data;
          end
          state_d = LSU_DONE;
        end else begin
          if (cnt_q != C_CNT_SAT) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (C_TIMEOUT_EN && (cnt_q == C_CNT_LAST)) begin
            err_d   = 1'b1;
            state_d = LSU_DONE;
          end
        end
      end

      LSU_DONE: begin
        if (core_state == UPDATE) begin
          state_d = LSU_IDLE;
        end
      end

      default: state_d = LSU_IDLE;
    endcase
  end

  assign mem_read_address  = addr_q;
  assign mem_write_address = addr_q;
  assign mem_write_data    = data_q;
  assign lsu_state         = state_q;
  assign lsu_out           = out_q;
  assign lsu_error         = err_q;

endmodule
`default_nettype wire
